// File: rtl/hazard_controller_pkg.sv
// Shared constants for the hazard controller: RV32I opcode classes, forwarding-select
// encodings and halt FSM states.
package hazard_controller_pkg;

  localparam logic [6:0] OP_ARITH     = 7'b0110011;
  localparam logic [6:0] OP_ARITH_IMM = 7'b0010011;
  localparam logic [6:0] OP_LOAD      = 7'b0000011;
  localparam logic [6:0] OP_STORE     = 7'b0100011;
  localparam logic [6:0] OP_BRANCH    = 7'b1100011;
  localparam logic [6:0] OP_JAL       = 7'b1101111;
  localparam logic [6:0] OP_JALR      = 7'b1100111;
  localparam logic [6:0] OP_LUI       = 7'b0110111;
  localparam logic [6:0] OP_AUIPC     = 7'b0010111;
  localparam logic [6:0] OP_ECALL     = 7'b1110011;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  typedef enum logic [1:0] {
    StRun    = 2'd0,
    StDrain  = 2'd1,
    StHalted = 2'd2
  } halt_state_e;

  // The youngest producer wins: EX/MEM data is newer than MEM/WB data.
  function automatic logic [1:0] fwd_select(input logic hit_ex, input logic hit_mem);
    if (hit_ex) begin
      return FWD_EXMEM;
    end else if (hit_mem) begin
      return FWD_MEMWB;
    end
    return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_controller_decoder.sv
// Combinational register-use decoder: which sources an instruction reads, and whether it
// writes rd or reads memory. An invalid (bubble) slot uses and writes nothing.
module inst_reg_use_decoder
  import hazard_controller_pkg::*;
#(
  parameter int unsigned REG_AW = 5
) (
  input  logic [31:0]       inst_i,
  input  logic              valid_i,
  output logic [REG_AW-1:0] rs1_o,
  output logic [REG_AW-1:0] rs2_o,
  output logic [REG_AW-1:0] rd_o,
  output logic              uses_rs1_o,
  output logic              uses_rs2_o,
  output logic              reg_write_o,
  output logic              mem_read_o
);

  logic [6:0] opcode;
  logic       unused_inst_bits;

  assign opcode           = inst_i[6:0];
  assign rd_o             = inst_i[7 +: REG_AW];
  assign rs1_o            = inst_i[15 +: REG_AW];
  assign rs2_o            = inst_i[20 +: REG_AW];
  assign unused_inst_bits = ^{inst_i[31:25], inst_i[14:12]};

  always_comb begin
    uses_rs1_o  = 1'b0;
    uses_rs2_o  = 1'b0;
    reg_write_o = 1'b0;
    mem_read_o  = 1'b0;
    if (valid_i) begin
      case (opcode)
        OP_ARITH: begin
          uses_rs1_o  = 1'b1;
          uses_rs2_o  = 1'b1;
          reg_write_o = 1'b1;
        end
        OP_STORE, OP_BRANCH: begin
          uses_rs1_o = 1'b1;
          uses_rs2_o = 1'b1;
        end
        OP_ARITH_IMM, OP_JALR: begin
          uses_rs1_o  = 1'b1;
          reg_write_o = 1'b1;
        end
        OP_LOAD: begin
          uses_rs1_o  = 1'b1;
          reg_write_o = 1'b1;
          mem_read_o  = 1'b1;
        end
        OP_JAL, OP_LUI, OP_AUIPC: begin
          reg_write_o = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline sequencing controller beside the ID stage: stalls, flushes, forwarding selects,
// RF bypass and ECALL halt draining. Define HAZARD_PERF_CNT_EN for stall/flush counters.
module hazard_controller
  import hazard_controller_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned REG_AW       = 5
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [31:0] id_inst_i,
  input  logic        id_valid_i,
  input  logic        id_halt_cond_i,
  input  logic        ex_redirect_i,
  output logic        pc_write_o,
  output logic        ifid_write_o,
  output logic        ifid_flush_o,
  output logic        idex_bubble_o,
  output logic [1:0]  fwd_a_o,
  output logic [1:0]  fwd_b_o,
  output logic        id_bypass_a_o,
  output logic        id_bypass_b_o,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0] stall_count_o,
  output logic [31:0] flush_count_o,
`endif
  output logic        is_halted_o
);

  localparam int unsigned CntW = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(DRAIN_CYCLES - 1);

  logic [REG_AW-1:0] id_rs1, id_rs2, id_rd;
  logic              id_uses_rs1, id_uses_rs2, id_reg_write, id_mem_read;

  inst_reg_use_decoder #(
    .REG_AW(REG_AW)
  ) u_decoder (
    .inst_i      (id_inst_i),
    .valid_i     (id_valid_i),
    .rs1_o       (id_rs1),
    .rs2_o       (id_rs2),
    .rd_o        (id_rd),
    .uses_rs1_o  (id_uses_rs1),
    .uses_rs2_o  (id_uses_rs2),
    .reg_write_o (id_reg_write),
    .mem_read_o  (id_mem_read)
  );

  // Shadow of {rd, reg_write, mem_read} for the instructions in EX, MEM and WB.
  logic [REG_AW-1:0] ex_rd_q, ex_rd_d, mem_rd_q, wb_rd_q;
  logic              ex_we_q, ex_we_d, mem_we_q, wb_we_q;
  logic              ex_mr_q, ex_mr_d, mem_mr_q;

  logic [1:0]        fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  halt_state_e       state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  logic ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b;
  logic load_use, is_ecall;

  always_comb begin
    ex_hit_a  = id_uses_rs1 && ex_we_q && (ex_rd_q != '0) && (id_rs1 == ex_rd_q);
    ex_hit_b  = id_uses_rs2 && ex_we_q && (ex_rd_q != '0) && (id_rs2 == ex_rd_q);
    mem_hit_a = id_uses_rs1 && mem_we_q && (mem_rd_q != '0) && (id_rs1 == mem_rd_q);
    mem_hit_b = id_uses_rs2 && mem_we_q && (mem_rd_q != '0) && (id_rs2 == mem_rd_q);
    load_use  = ex_mr_q && (ex_hit_a || ex_hit_b);
    is_ecall  = id_valid_i && (id_inst_i[6:0] == OP_ECALL);
    id_bypass_a_o = id_uses_rs1 && wb_we_q && (wb_rd_q != '0) && (id_rs1 == wb_rd_q);
    id_bypass_b_o = id_uses_rs2 && wb_we_q && (wb_rd_q != '0) && (id_rs2 == wb_rd_q);
  end

  always_comb begin
    pc_write_o    = 1'b1;
    ifid_write_o  = 1'b1;
    ifid_flush_o  = 1'b0;
    idex_bubble_o = 1'b0;
    if (state_q != StRun) begin
      pc_write_o    = 1'b0;
      ifid_write_o  = 1'b0;
      idex_bubble_o = 1'b1;
    end else if (ex_redirect_i) begin
      // The load-use consumer is flushed, so no stall is needed alongside a redirect.
      ifid_flush_o  = 1'b1;
      idex_bubble_o = 1'b1;
    end else if (load_use) begin
      pc_write_o    = 1'b0;
      ifid_write_o  = 1'b0;
      idex_bubble_o = 1'b1;
    end
  end

  always_comb begin
    ex_rd_d = idex_bubble_o ? '0 : id_rd;
    ex_we_d = idex_bubble_o ? 1'b0 : id_reg_write;
    ex_mr_d = idex_bubble_o ? 1'b0 : id_mem_read;
    fwd_a_d = idex_bubble_o ? FWD_RF : fwd_select(ex_hit_a, mem_hit_a);
    fwd_b_d = idex_bubble_o ? FWD_RF : fwd_select(ex_hit_b, mem_hit_b);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StRun: begin
        if (is_ecall && id_halt_cond_i && !ex_redirect_i && !load_use) begin
          state_d = StDrain;
          cnt_d   = CntLoad;
        end
      end
      StDrain: begin
        if (cnt_q == '0) begin
          state_d = StHalted;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StHalted: ;
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ex_rd_q  <= '0;
      ex_we_q  <= 1'b0;
      ex_mr_q  <= 1'b0;
      mem_rd_q <= '0;
      mem_we_q <= 1'b0;
      mem_mr_q <= 1'b0;
      wb_rd_q  <= '0;
      wb_we_q  <= 1'b0;
      fwd_a_q  <= FWD_RF;
      fwd_b_q  <= FWD_RF;
      state_q  <= StRun;
      cnt_q    <= '0;
    end else begin
      ex_rd_q  <= ex_rd_d;
      ex_we_q  <= ex_we_d;
      ex_mr_q  <= ex_mr_d;
      mem_rd_q <= ex_rd_q;
      mem_we_q <= ex_we_q;
      mem_mr_q <= ex_mr_q;
      wb_rd_q  <= mem_rd_q;
      wb_we_q  <= mem_we_q;
      fwd_a_q  <= fwd_a_d;
      fwd_b_q  <= fwd_b_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
    end
  end

  logic unused_mem_mr;
  assign unused_mem_mr = mem_mr_q;

  assign fwd_a_o     = fwd_a_q;
  assign fwd_b_o     = fwd_b_q;
  assign is_halted_o = (state_q == StHalted);

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;
  logic        stall_evt, flush_evt;

  assign stall_evt = (state_q == StRun) && load_use && !ex_redirect_i;
  assign flush_evt = (state_q == StRun) && ex_redirect_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_evt && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (flush_evt && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + 32'd1;
      end
    end
  end

  assign stall_count_o = stall_cnt_q;
  assign flush_count_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: a cycle-level pipeline model checked on every
// negedge, plus hand-computed literal expectations in the directed sequence.
module tb_hazard_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] id_inst;
  logic        id_valid, id_halt_cond, ex_redirect;
  logic        pc_write, ifid_write, ifid_flush, idex_bubble;
  logic [1:0]  fwd_a, fwd_b;
  logic        id_bypass_a, id_bypass_b, is_halted;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_count, flush_count;
`endif

  always #5 clk = ~clk;

  hazard_controller dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .id_inst_i      (id_inst),
    .id_valid_i     (id_valid),
    .id_halt_cond_i (id_halt_cond),
    .ex_redirect_i  (ex_redirect),
    .pc_write_o     (pc_write),
    .ifid_write_o   (ifid_write),
    .ifid_flush_o   (ifid_flush),
    .idex_bubble_o  (idex_bubble),
    .fwd_a_o        (fwd_a),
    .fwd_b_o        (fwd_b),
    .id_bypass_a_o  (id_bypass_a),
    .id_bypass_b_o  (id_bypass_b),
`ifdef HAZARD_PERF_CNT_EN
    .stall_count_o  (stall_count),
    .flush_count_o  (flush_count),
`endif
    .is_halted_o    (is_halted)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit started = 1'b0;

  task automatic check1(input string name, input logic got, input logic want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0b want %0b at %0t", name, got, want, $time);
    end
  endtask

  task automatic check2(input string name, input logic [1:0] got, input logic [1:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0b want %0b at %0t", name, got, want, $time);
    end
  endtask

  // ---------------- instruction builders ----------------
  function automatic logic [31:0] r_add(input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [4:0] rs2);
    return {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] r_sub(input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [4:0] rs2);
    return {7'b0100000, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] i_lw(input logic [4:0] rd, input logic [4:0] rs1);
    return {12'd0, rs1, 3'b010, rd, 7'b0000011};
  endfunction
  function automatic logic [31:0] i_addi(input logic [4:0] rd, input logic [4:0] rs1);
    return {12'd1, rs1, 3'b000, rd, 7'b0010011};
  endfunction
  localparam logic [31:0] ECALL = 32'h0000_0073;

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [4:0] rd;
    logic       we;
    logic       mr;
  } slot_t;

  typedef struct packed {
    logic pcw, ifw, fl, bub, lu, run;
  } ctl_t;

  slot_t      pipe [3];  // 0 = EX, 1 = MEM, 2 = WB
  logic [1:0] m_fwd_a, m_fwd_b;
  bit         acc_valid;
  int         acc_cyc, cyc;

  // bit0: reads rs1, bit1: reads rs2
  function automatic logic [1:0] srcs(input logic [31:0] i, input logic v);
    if (!v) return 2'b00;
    case (i[6:0])
      7'b0110011, 7'b0100011, 7'b1100011: return 2'b11;
      7'b0010011, 7'b0000011, 7'b1100111: return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic writes(input logic [31:0] i, input logic v);
    if (!v) return 1'b0;
    case (i[6:0])
      7'b0110011, 7'b0010011, 7'b0000011, 7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111:
        return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic dep(input slot_t s, input logic [4:0] r);
    return s.we && (s.rd != 5'd0) && (s.rd == r);
  endfunction

  function automatic ctl_t exp_ctl();
    ctl_t       c;
    logic [1:0] m;
    m     = srcs(id_inst, id_valid);
    c.run = !(acc_valid && (cyc > acc_cyc));
    c.lu  = pipe[0].mr && ((m[0] && dep(pipe[0], id_inst[19:15])) ||
                           (m[1] && dep(pipe[0], id_inst[24:20])));
    if (!c.run)          c = '{pcw: 0, ifw: 0, fl: 0, bub: 1, lu: c.lu, run: 0};
    else if (ex_redirect) c = '{pcw: 1, ifw: 1, fl: 1, bub: 1, lu: c.lu, run: 1};
    else if (c.lu)       c = '{pcw: 0, ifw: 0, fl: 0, bub: 1, lu: 1, run: 1};
    else                 c = '{pcw: 1, ifw: 1, fl: 0, bub: 0, lu: 0, run: 1};
    return c;
  endfunction

  function automatic logic [1:0] exp_fwd(input logic used, input logic [4:0] r);
    if (used && dep(pipe[0], r)) return 2'b01;
    if (used && dep(pipe[1], r)) return 2'b10;
    return 2'b00;
  endfunction

  always @(posedge clk) begin
    ctl_t       c;
    logic [1:0] m;
    slot_t      nx;
    if (reset) begin
      for (int i = 0; i < 3; i++) pipe[i] = '0;
      m_fwd_a   = 2'b00;
      m_fwd_b   = 2'b00;
      acc_valid = 1'b0;
      acc_cyc   = 0;
      cyc       = 0;
    end else begin
      c = exp_ctl();
      m = srcs(id_inst, id_valid);
      m_fwd_a = c.bub ? 2'b00 : exp_fwd(m[0], id_inst[19:15]);
      m_fwd_b = c.bub ? 2'b00 : exp_fwd(m[1], id_inst[24:20]);
      if (c.run && id_valid && (id_inst[6:0] == 7'b1110011) && id_halt_cond &&
          !ex_redirect && !c.lu) begin
        acc_valid = 1'b1;
        acc_cyc   = cyc;
      end
      nx.rd = id_inst[11:7];
      nx.we = writes(id_inst, id_valid);
      nx.mr = id_valid && (id_inst[6:0] == 7'b0000011);
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = c.bub ? slot_t'('0) : nx;
      cyc++;
    end
  end

  // Single compare process: every non-reset cycle, DUT against the model.
  always @(negedge clk) begin
    ctl_t       c;
    logic [1:0] m;
    if (started && !reset) begin
      c = exp_ctl();
      m = srcs(id_inst, id_valid);
      check1("model.pc_write", pc_write, c.pcw);
      check1("model.ifid_write", ifid_write, c.ifw);
      check1("model.ifid_flush", ifid_flush, c.fl);
      check1("model.idex_bubble", idex_bubble, c.bub);
      check2("model.fwd_a", fwd_a, m_fwd_a);
      check2("model.fwd_b", fwd_b, m_fwd_b);
      check1("model.bypass_a", id_bypass_a, m[0] && dep(pipe[2], id_inst[19:15]));
      check1("model.bypass_b", id_bypass_b, m[1] && dep(pipe[2], id_inst[24:20]));
      check1("model.is_halted", is_halted, acc_valid && (cyc >= acc_cyc + 4));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic drive(input logic [31:0] inst, input logic v, input logic cond,
                       input logic redir);
    @(posedge clk);
    #1;
    id_inst      = inst;
    id_valid     = v;
    id_halt_cond = cond;
    ex_redirect  = redir;
    #2;
  endtask

  task automatic idle();
    drive(32'h0000_0013, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset        = 1'b1;
    id_inst      = 32'h0000_0013;
    id_valid     = 1'b0;
    id_halt_cond = 1'b0;
    ex_redirect  = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    #2;
  endtask

  initial begin
    reset        = 1'b1;
    id_inst      = 32'h0000_0013;
    id_valid     = 1'b0;
    id_halt_cond = 1'b0;
    ex_redirect  = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset   = 1'b0;
    started = 1'b1;
    #2;
    check1("rst.pc_write", pc_write, 1'b1);
    check1("rst.ifid_write", ifid_write, 1'b1);
    check1("rst.ifid_flush", ifid_flush, 1'b0);
    check1("rst.idex_bubble", idex_bubble, 1'b0);
    check2("rst.fwd_a", fwd_a, 2'b00);
    check2("rst.fwd_b", fwd_b, 2'b00);
    check1("rst.is_halted", is_halted, 1'b0);
    idle();

    // Load-use stall, then MEM/WB forward into the consumer.
    drive(i_lw(5'd5, 5'd1), 1'b1, 1'b0, 1'b0);
    drive(r_add(5'd6, 5'd5, 5'd2), 1'b1, 1'b0, 1'b0);
    check1("stall.pc_write", pc_write, 1'b0);
    check1("stall.ifid_write", ifid_write, 1'b0);
    check1("stall.idex_bubble", idex_bubble, 1'b1);
    drive(r_add(5'd6, 5'd5, 5'd2), 1'b1, 1'b0, 1'b0);
    check1("stall.release", pc_write, 1'b1);
    idle();
    check2("stall.fwd_a", fwd_a, 2'b10);
    check2("stall.fwd_b", fwd_b, 2'b00);

    // EX/MEM forwarding on both operands, then the same with rd = x0.
    drive(r_add(5'd3, 5'd1, 5'd2), 1'b1, 1'b0, 1'b0);
    drive(r_sub(5'd4, 5'd3, 5'd3), 1'b1, 1'b0, 1'b0);
    idle();
    check2("exmem.fwd_a", fwd_a, 2'b01);
    check2("exmem.fwd_b", fwd_b, 2'b01);
    drive(r_add(5'd0, 5'd1, 5'd2), 1'b1, 1'b0, 1'b0);
    drive(r_sub(5'd4, 5'd0, 5'd0), 1'b1, 1'b0, 1'b0);
    idle();
    check2("x0.fwd_a", fwd_a, 2'b00);
    check2("x0.fwd_b", fwd_b, 2'b00);

    // WB bypass: writer three instructions ahead of the reader.
    drive(r_add(5'd7, 5'd1, 5'd2), 1'b1, 1'b0, 1'b0);
    drive(i_addi(5'd8, 5'd1), 1'b1, 1'b0, 1'b0);
    drive(i_addi(5'd9, 5'd1), 1'b1, 1'b0, 1'b0);
    drive(r_add(5'd10, 5'd7, 5'd1), 1'b1, 1'b0, 1'b0);
    check1("bypass.a", id_bypass_a, 1'b1);
    check1("bypass.b", id_bypass_b, 1'b0);

    // Load-use x0 destination never stalls.
    drive(i_lw(5'd0, 5'd1), 1'b1, 1'b0, 1'b0);
    drive(r_add(5'd6, 5'd0, 5'd0), 1'b1, 1'b0, 1'b0);
    check1("x0load.pc_write", pc_write, 1'b1);

    // Redirect beats load-use.
    idle();
    drive(i_lw(5'd5, 5'd1), 1'b1, 1'b0, 1'b0);
    drive(r_add(5'd6, 5'd5, 5'd2), 1'b1, 1'b0, 1'b1);
    check1("redir.ifid_flush", ifid_flush, 1'b1);
    check1("redir.idex_bubble", idex_bubble, 1'b1);
    check1("redir.pc_write", pc_write, 1'b1);
    check1("redir.ifid_write", ifid_write, 1'b1);
    idle();
    check1("redir.no_stall", pc_write, 1'b1);

    // ECALL squashed by redirect, and ECALL without halt condition: both keep running.
    drive(ECALL, 1'b1, 1'b1, 1'b1);
    idle();
    check1("squash.pc_write", pc_write, 1'b1);
    drive(ECALL, 1'b1, 1'b0, 1'b0);
    idle();
    check1("nocond.pc_write", pc_write, 1'b1);
    idle();

    // Halt drain: accepted at t, halted from t+4, redirect ignored while draining.
    drive(ECALL, 1'b1, 1'b1, 1'b0);
    check1("halt.accept_pc_write", pc_write, 1'b1);
    idle();
    check1("halt.t1_pc_write", pc_write, 1'b0);
    check1("halt.t1_is_halted", is_halted, 1'b0);
    drive(32'h0000_0013, 1'b0, 1'b0, 1'b1);
    check1("halt.t2_flush", ifid_flush, 1'b0);
    check1("halt.t2_pc_write", pc_write, 1'b0);
    idle();
    check1("halt.t3_is_halted", is_halted, 1'b0);
    idle();
    check1("halt.t4_is_halted", is_halted, 1'b1);
    check1("halt.t4_pc_write", pc_write, 1'b0);
    idle();
    idle();

    // Reset from HALTED, then reset in the middle of a drain.
    do_reset();
    check1("rst2.is_halted", is_halted, 1'b0);
    drive(ECALL, 1'b1, 1'b1, 1'b0);
    idle();
    check1("middrain.pc_write", pc_write, 1'b0);
    do_reset();
    check1("middrain.is_halted", is_halted, 1'b0);
    check1("middrain.pc_write", pc_write, 1'b1);
    for (int k = 0; k < 5; k++) idle();

    @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
